// File: rtl/poly_mod_sqr_chain.sv
// Multi-channel iterated modular squaring engine: computes x^(2^T) mod MODULUS per channel
// by time-interleaving independent chains through one pipelined squarer.
module poly_mod_sqr_chain #(
    parameter int unsigned WORD_BITS       = 8,
    parameter int unsigned NUM_WORDS       = 4,
    parameter int unsigned REDUN_WORD_BITS = 1,
    parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS = 32'hFFFF_FFFB,
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned MULT_LAT        = 6,
    parameter int unsigned ITER_BITS       = 32,
    localparam int unsigned I_WORD    = NUM_WORDS + 1,
    localparam int unsigned COEF_BITS = WORD_BITS + REDUN_WORD_BITS,
    localparam int unsigned DAT_BITS  = I_WORD * COEF_BITS,
    localparam int unsigned CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_val,
    output logic                 o_rdy,
    input  logic [CH_BITS-1:0]   i_ch,
    input  logic [ITER_BITS-1:0] i_iters,
    input  logic [DAT_BITS-1:0]  i_dat,
    output logic                 o_val,
    input  logic                 i_rdy,
    output logic [CH_BITS-1:0]   o_ch,
    output logic [DAT_BITS-1:0]  o_dat,
    output logic [NUM_CH-1:0]    o_busy
);

    localparam int unsigned M_BITS    = WORD_BITS * NUM_WORDS;
    localparam int unsigned RAW_BITS  = M_BITS + COEF_BITS + 1;
    localparam int unsigned SQ_BITS   = 2 * M_BITS;
    localparam int unsigned SLOT_BITS = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RUN, ST_DONE} ch_state_t;

    ch_state_t              state_q [NUM_CH];
    ch_state_t              state_d [NUM_CH];
    logic [DAT_BITS-1:0]    opnd_q  [NUM_CH];
    logic [DAT_BITS-1:0]    opnd_d  [NUM_CH];
    logic [ITER_BITS-1:0]   cnt_q   [NUM_CH];
    logic [ITER_BITS-1:0]   cnt_d   [NUM_CH];
    logic [SLOT_BITS-1:0]   slot_q;
    logic [DAT_BITS-1:0]    pipe_dat [MULT_LAT];
    logic [MULT_LAT-1:0]    pipe_vld;
    logic                   iss_vld;
    logic [DAT_BITS-1:0]    iss_dat;
    logic                   load;
    logic                   unload;
    logic                   o_val_d;
    logic [CH_BITS-1:0]     o_ch_d;
    logic [DAT_BITS-1:0]    o_dat_d;
    logic [NUM_CH-1:0]      o_busy_d;

    // Squarer core arithmetic: collapse redundant digits, square, reduce, re-expand canonically.
    function automatic logic [DAT_BITS-1:0] mod_square(input logic [DAT_BITS-1:0] d);
        logic [RAW_BITS-1:0] acc;
        logic [M_BITS-1:0]   r;
        logic [SQ_BITS-1:0]  sq;
        logic [M_BITS-1:0]   s;
        acc = '0;
        for (int k = 0; k < int'(I_WORD); k++)
            acc = acc + (RAW_BITS'(d[k*COEF_BITS +: COEF_BITS]) << (k*WORD_BITS));
        r  = M_BITS'(acc % RAW_BITS'(MODULUS));
        sq = SQ_BITS'(r) * SQ_BITS'(r);
        s  = M_BITS'(sq % SQ_BITS'(MODULUS));
        mod_square = '0;
        for (int k = 0; k < int'(NUM_WORDS); k++)
            mod_square[k*COEF_BITS +: COEF_BITS] = COEF_BITS'(s[k*WORD_BITS +: WORD_BITS]);
    endfunction

    assign o_rdy  = (32'(i_ch) < NUM_CH) && (state_q[i_ch] == ST_IDLE);
    assign load   = i_val && o_rdy;
    assign unload = o_val && i_rdy;

    // Channel FSMs, issue mux and output arbitration.
    always_comb begin
        state_d  = state_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        iss_vld  = 1'b0;
        iss_dat  = '0;
        o_val_d  = o_val;
        o_ch_d   = o_ch;
        o_dat_d  = o_dat;
        o_busy_d = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            unique case (state_q[c])
                ST_IDLE: begin
                    if (load && (i_ch == CH_BITS'(c))) begin
                        opnd_d[c]  = i_dat;
                        cnt_d[c]   = i_iters;
                        state_d[c] = (i_iters == '0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (slot_q == SLOT_BITS'(c)) begin
                        iss_vld    = 1'b1;
                        iss_dat    = opnd_q[c];
                        state_d[c] = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if ((slot_q == SLOT_BITS'(c)) && pipe_vld[MULT_LAT-1]) begin
                        cnt_d[c] = cnt_q[c] - ITER_BITS'(1);
                        if (cnt_q[c] == ITER_BITS'(1)) begin
                            opnd_d[c]  = pipe_dat[MULT_LAT-1];
                            state_d[c] = ST_DONE;
                        end else begin
                            iss_vld = 1'b1;
                            iss_dat = pipe_dat[MULT_LAT-1];
                        end
                    end
                end
                ST_DONE: begin
                    if (unload && (o_ch == CH_BITS'(c)))
                        state_d[c] = ST_IDLE;
                end
                default: state_d[c] = ST_IDLE;
            endcase
            o_busy_d[c] = (state_d[c] != ST_IDLE);
        end
        // A presented result stays frozen until consumed; otherwise the lowest DONE channel wins.
        if (!(o_val && !i_rdy)) begin
            o_val_d = 1'b0;
            for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
                if (state_d[c] == ST_DONE) begin
                    o_val_d = 1'b1;
                    o_ch_d  = CH_BITS'(c);
                    o_dat_d = opnd_d[c];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < int'(NUM_CH); c++) state_q[c] <= ST_IDLE;
            slot_q   <= '0;
            pipe_vld <= '0;
            o_val    <= 1'b0;
            o_ch     <= '0;
            o_dat    <= '0;
            o_busy   <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= (slot_q == SLOT_BITS'(MULT_LAT - 1)) ? '0 : slot_q + SLOT_BITS'(1);
            pipe_vld[0] <= iss_vld;
            for (int k = 1; k < int'(MULT_LAT); k++) pipe_vld[k] <= pipe_vld[k-1];
            o_val       <= o_val_d;
            o_ch        <= o_ch_d;
            o_dat       <= o_dat_d;
            o_busy      <= o_busy_d;
        end
    end

    // Datapath registers carry no reset; validity is tracked by state and pipe_vld.
    always_ff @(posedge i_clk) begin
        opnd_q      <= opnd_d;
        cnt_q       <= cnt_d;
        pipe_dat[0] <= mod_square(iss_dat);
        for (int k = 1; k < int'(MULT_LAT); k++) pipe_dat[k] <= pipe_dat[k-1];
    end

endmodule

// File: tb/tb_poly_mod_sqr_chain.sv
// Self-checking bench for poly_mod_sqr_chain against a modular-exponentiation reference model.
module tb_poly_mod_sqr_chain;

    localparam int unsigned WB  = 8;
    localparam int unsigned NW  = 4;
    localparam int unsigned RB  = 1;
    localparam int unsigned NCH = 2;
    localparam int unsigned LAT = 6;
    localparam int unsigned IB  = 32;
    localparam int unsigned CB  = WB + RB;
    localparam int unsigned IW  = NW + 1;
    localparam int unsigned DW  = IW * CB;
    localparam longint unsigned M = 64'h0000_0000_FFFF_FFFB;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_val;
    logic          o_rdy;
    logic          i_ch;
    logic [IB-1:0] i_iters;
    logic [DW-1:0] i_dat;
    logic          o_val;
    logic          i_rdy;
    logic          o_ch;
    logic [DW-1:0] o_dat;
    logic [NCH-1:0] o_busy;

    int n_pass   = 0;
    int n_total  = 0;
    int abs_cyc  = 0;
    int slot_cyc = 0;

    always #5 clk = ~clk;

    poly_mod_sqr_chain #(
        .WORD_BITS(WB), .NUM_WORDS(NW), .REDUN_WORD_BITS(RB), .MODULUS(32'hFFFF_FFFB),
        .NUM_CH(NCH), .MULT_LAT(LAT), .ITER_BITS(IB)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_val(i_val), .o_rdy(o_rdy), .i_ch(i_ch),
        .i_iters(i_iters), .i_dat(i_dat), .o_val(o_val), .i_rdy(i_rdy), .o_ch(o_ch),
        .o_dat(o_dat), .o_busy(o_busy)
    );

    // Edge count since the last reset edge equals the specified slot counter value.
    always @(posedge clk) begin
        abs_cyc <= abs_cyc + 1;
        if (i_rst) slot_cyc <= 0;
        else       slot_cyc <= slot_cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic longint unsigned collapse(input logic [DW-1:0] d);
        longint unsigned acc = 0;
        for (int k = 0; k < int'(IW); k++) acc += 64'(d[k*CB +: CB]) << (k*WB);
        return acc % M;
    endfunction

    function automatic longint unsigned model_pow(input longint unsigned x, input int t);
        longint unsigned r = x % M;
        for (int i = 0; i < t; i++) r = (r * r) % M;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_dat();
        logic [DW-1:0] x = '0;
        for (int k = 0; k < int'(IW); k++) x[k*CB +: CB] = CB'($urandom);
        return x;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one load; returns the window in which o_val is specified to rise.
    task automatic load_ch(input int c, input logic [DW-1:0] x, input int t, output int exp_win);
        int s1;
        int d;
        i_val   = 1'b1;
        i_ch    = 1'(c);
        i_iters = IB'(t);
        i_dat   = x;
        #1;
        check("o_rdy_on_load", 64'(o_rdy), 64'd1);
        s1 = (slot_cyc + 1) % int'(LAT);
        d  = (c - s1 + int'(LAT)) % int'(LAT);
        exp_win = (t == 0) ? abs_cyc + 1 : abs_cyc + 2 + d + t * int'(LAT);
        step();
        i_val = 1'b0;
    endtask

    task automatic wait_oval(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (o_val) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic run_one(input int c, input logic [DW-1:0] x, input int t);
        int ew;
        bit ok;
        longint unsigned ev;
        ev = model_pow(collapse(x), t);
        i_rdy = 1'b0;
        load_ch(c, x, t, ew);
        check("busy_after_load", 64'(o_busy), 64'(1 << c));
        wait_oval(t * int'(LAT) + 3 * int'(LAT), ok);
        check("oval_timeout", 64'(ok), 64'd1);
        check("latency", 64'(abs_cyc), 64'(ew));
        check("o_ch", 64'(o_ch), 64'(c));
        check("value", collapse(o_dat), ev);
        i_rdy = 1'b1;
        step();
        i_rdy = 1'b0;
        check("oval_after_unload", 64'(o_val), 64'd0);
        check("busy_after_unload", 64'(o_busy), 64'd0);
    endtask

    initial begin
        int ew0;
        int ew1;
        bit ok;
        logic [DW-1:0] x;
        longint unsigned e0;
        longint unsigned e1;

        i_rst = 1'b1; i_val = 1'b0; i_ch = 1'b0; i_iters = '0; i_dat = '0; i_rdy = 1'b0;
        repeat (3) step();
        check("rst_o_val", 64'(o_val), 64'd0);
        check("rst_o_busy", 64'(o_busy), 64'd0);
        check("rst_o_ch", 64'(o_ch), 64'd0);
        check("rst_o_dat", 64'(o_dat), 64'd0);
        i_rst = 1'b0;

        run_one(0, DW'(3), 1);
        run_one(0, DW'(3), 5);

        // Two interleaved chains with output back-pressure.
        e0 = model_pow(2, 10);
        e1 = model_pow(5, 10);
        i_rdy = 1'b0;
        load_ch(0, DW'(2), 10, ew0);
        load_ch(1, DW'(5), 10, ew1);
        check("busy_both", 64'(o_busy), 64'd3);
        wait_oval(20 * int'(LAT), ok);
        check("pair_timeout", 64'(ok), 64'd1);
        check("pair_latency_ch0", 64'(abs_cyc), 64'(ew0));
        for (int i = 0; i < 20; i++) begin
            check("hold_o_val", 64'(o_val), 64'd1);
            check("hold_o_ch", 64'(o_ch), 64'd0);
            check("hold_value", collapse(o_dat), e0);
            step();
        end
        check("busy_both_done", 64'(o_busy), 64'd3);
        i_rdy = 1'b1;
        step();
        i_rdy = 1'b0;
        check("next_o_val", 64'(o_val), 64'd1);
        check("next_o_ch", 64'(o_ch), 64'd1);
        check("next_value", collapse(o_dat), e1);
        i_rdy = 1'b1;
        step();
        i_rdy = 1'b0;
        check("pair_drained_val", 64'(o_val), 64'd0);
        check("pair_drained_busy", 64'(o_busy), 64'd0);

        // T=0 passes the redundant operand through untouched; busy channel rejects loads.
        x = rand_dat();
        x[CB-1:0] = 9'h123;
        load_ch(0, x, 0, ew0);
        check("t0_o_val", 64'(o_val), 64'd1);
        check("t0_latency", 64'(abs_cyc), 64'(ew0));
        check("t0_o_dat", 64'(o_dat), 64'(x));
        check("t0_o_ch", 64'(o_ch), 64'd0);
        i_val = 1'b1; i_ch = 1'b0; i_dat = ~x; i_iters = IB'(7);
        #1;
        check("busy_reject_rdy", 64'(o_rdy), 64'd0);
        step();
        i_val = 1'b0;
        check("busy_reject_dat", 64'(o_dat), 64'(x));
        check("busy_reject_busy", 64'(o_busy), 64'd1);
        i_rdy = 1'b1;
        step();
        i_rdy = 1'b0;
        check("t0_unloaded", 64'(o_val), 64'd0);

        for (int r = 0; r < 6; r++)
            run_one(int'($urandom_range(0, 1)), rand_dat(), int'($urandom_range(1, 8)));

        // Reset mid-chain discards work and leaves no stray output.
        load_ch(1, rand_dat(), 100, ew1);
        repeat (40) step();
        check("midrun_busy", 64'(o_busy), 64'd2);
        i_rst = 1'b1;
        step();
        check("midrst_o_val", 64'(o_val), 64'd0);
        check("midrst_o_busy", 64'(o_busy), 64'd0);
        i_rst = 1'b0;
        for (int i = 0; i < 3 * int'(LAT) + 10; i++) begin
            check("no_spurious", 64'(o_val), 64'd0);
            step();
        end
        run_one(1, rand_dat(), 3);
        run_one(0, rand_dat(), 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
